// File: rtl/bin2bcd4_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Inputs above 10^DIGITS-1 saturate to all nines and raise ovf.
module bin2bcd4_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CW    = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(10 ** DIGITS - 1);
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [0:0] {IDLE, CONV} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [BIN_W-1:0]     bin_sr;
  logic [BCD_W-1:0]     acc;
  logic [CW-1:0]        cnt;
  logic                 range_flag;
  logic                 last_shift;
  logic [BCD_W-1:0]     acc_adj;
  logic [BCD_W+BIN_W-1:0] shifted;

  assign last_shift = (cnt == CW'(BIN_W - 1));

  // Add-3 correction on every digit >= 5, then shift {acc, bin_sr} left by one
  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    shifted = {acc_adj, bin_sr} << 1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)      state_nxt = CONV;
      CONV:    if (last_shift) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Output decode: busy follows the registered state only
  always_comb begin
    busy = (state == CONV);
  end

  // Datapath: operand capture, shift iterations and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr     <= '0;
      acc        <= '0;
      cnt        <= '0;
      range_flag <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      ovf        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr     <= bin;
            acc        <= '0;
            cnt        <= '0;
            range_flag <= (bin > MAX_VAL);
          end
        end
        CONV: begin
          acc    <= shifted[BCD_W+BIN_W-1:BIN_W];
          bin_sr <= shifted[BIN_W-1:0];
          cnt    <= cnt + 1'b1;
          if (last_shift) begin
            bcd  <= range_flag ? ALL_NINES : shifted[BCD_W+BIN_W-1:BIN_W];
            ovf  <= range_flag;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd4_seq.sv
// Self-checking bench for bin2bcd4_seq against a decimal arithmetic model.
module tb_bin2bcd4_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;

  int unsigned checks;
  int unsigned failures;
  logic [15:0] prev_bcd;
  logic        prev_ovf;

  bin2bcd4_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int unsigned v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Called at a negedge with the DUT idle (or in its done cycle); returns at
  // the negedge following the accepting edge with start low and bin scrambled.
  task automatic start_conv(input int unsigned v);
    bin   = 14'(v);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin   = 14'($urandom);
  endtask

  // Waits for done, checking latency, busy length, result hold and the result.
  task automatic wait_done(input int unsigned v, input bit hold);
    int unsigned k;
    int unsigned busy_cnt;
    logic [15:0] exp;
    k = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && k < 40) begin
      check("hold_bcd", 32'(bcd), 32'(prev_bcd));
      check("hold_ovf", 32'(ovf), 32'(prev_ovf));
      if (busy === 1'b1) busy_cnt++;
      if (hold) begin
        start = 1'b1;
        bin   = 14'($urandom);
      end
      @(negedge clk);
      k++;
    end
    if (hold) start = 1'b0;
    exp = ref_bcd(v);
    check("latency", k, 14);
    check("busy_cycles", busy_cnt, 14);
    check("busy_at_done", 32'(busy), 0);
    check("bcd", 32'(bcd), 32'(exp));
    check("ovf", 32'(ovf), (v > 9999) ? 32'd1 : 32'd0);
    for (int d = 0; d < 4; d++)
      check("digit_range", 32'(bcd[4*d +: 4] <= 4'd9), 1);
    prev_bcd = exp;
    prev_ovf = (v > 9999);
  endtask

  task automatic single_conv(input int unsigned v);
    start_conv(v);
    wait_done(v, 1'b0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    int unsigned vals[$];
    int unsigned boundary[9];
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_bcd", 32'(bcd), 0);
    check("rst_ovf", 32'(ovf), 0);
    prev_bcd = '0;
    prev_ovf = 1'b0;

    // Basic conversion and boundaries, including overflow and flag clearing
    boundary = '{1234, 0, 9, 10, 9999, 10000, 16383, 42, 100};
    foreach (boundary[i]) single_conv(boundary[i]);

    // start held high with bin changing mid-conversion, then back-to-back
    start_conv(2468);
    wait_done(2468, 1'b1);
    start_conv(5678);
    wait_done(5678, 1'b0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);

    // Reset during a conversion aborts it with no done pulse
    start_conv(4321);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_bcd", 32'(bcd), 0);
    check("abort_ovf", 32'(ovf), 0);
    prev_bcd = '0;
    prev_ovf = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(done), 0);
    end
    single_conv(4321);

    // Randomized back-to-back stream, starting each in the previous done cycle
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 7))
        0:       vals.push_back($urandom_range(9990, 10010));
        1:       vals.push_back($urandom_range(0, 20));
        2:       vals.push_back($urandom_range(16370, 16383));
        default: vals.push_back($urandom_range(0, 16383));
      endcase
    end
    start_conv(vals[0]);
    for (int i = 0; i < vals.size(); i++) begin
      wait_done(vals[i], 1'b0);
      if (i + 1 < vals.size()) start_conv(vals[i+1]);
    end
    @(negedge clk);
    check("done_one_cycle", 32'(done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
